// File: rtl/crossy_lanes.sv
// Crossy Road playfield engine: scrolling obstacle lanes, fixed chicken, per-frame
// collision detection and a lives / game-over state machine with a registered pixel colour.
module crossy_lanes #(
    parameter int N_LANES     = 3,
    parameter int OB_W        = 50,
    parameter int OB_H        = 30,
    parameter int LANE_PITCH  = 150,
    parameter int OB_X_OFFSET = 250,
    parameter int MOVE_STEP   = 10,
    parameter int LIVES       = 3,
    parameter int HIT_FRAMES  = 60,
    parameter int CHICK_X     = 310,
    parameter int CHICK_Y     = 400,
    parameter int CHICK_W     = 30,
    parameter int CHICK_H     = 40
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [9:0] i_hpos,
    input  logic [9:0] i_vpos,
    input  logic       i_display_on,
    input  logic       i_frame_tick,
    input  logic       i_move_btn,
    output logic [2:0] o_rgb,
    output logic [7:0] o_score,
    output logic [2:0] o_lives,
    output logic [1:0] o_state
);

    typedef enum logic [1:0] {
        ST_PLAY = 2'b00,
        ST_HIT  = 2'b01,
        ST_OVER = 2'b10
    } state_t;

    localparam int CNT_W = (HIT_FRAMES > 1) ? $clog2(HIT_FRAMES) : 1;

    function automatic logic [8:0] scroll_step(input logic [8:0] s);
        logic [9:0] t;
        t = {1'b0, s} + 10'(MOVE_STEP);
        if (t >= 10'd480) t = t - 10'd480;
        return t[8:0];
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [2:0] lane_speed(input logic [7:0] v);
        return 3'd1 + ((v[7:5] > 3'd3) ? 3'd3 : v[7:5]);
    endfunction

    state_t             state_q, state_d;
    logic [2:0]         lives_q, lives_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [8:0]         scroll_q, scroll_d;
    logic [7:0]         score_q, score_d;
    logic               btn_q;
    logic               flag_q;
    logic [2:0]         rgb_p1;

    logic               move_pulse;
    logic               flag_clr;
    logic               lanes_adv;
    logic               lanes_rst;
    logic [2:0]         speed;
    logic [N_LANES-1:0] obs_hit;
    logic               any_obs;
    logic               chick_hit;
    logic [10:0]        hpos11, vpos11;
    logic [2:0]         rgb_d;

    assign hpos11     = {1'b0, i_hpos};
    assign vpos11     = {1'b0, i_vpos};
    assign move_pulse = i_move_btn & ~btn_q;
    assign speed      = lane_speed(score_q);
    assign any_obs    = |obs_hit;
    assign chick_hit  = (hpos11 >= 11'(CHICK_X)) && (hpos11 < 11'(CHICK_X + CHICK_W)) &&
                        (vpos11 >= 11'(CHICK_Y)) && (vpos11 < 11'(CHICK_Y + CHICK_H));

    // Lanes: y derived from scroll each cycle, x stepped once per frame.
    for (genvar gi = 0; gi < N_LANES; gi++) begin : g_lane
        localparam int Y_BASE = (gi * LANE_PITCH) % 480;
        localparam int X_RST  = (gi * OB_X_OFFSET) % 640;

        logic [9:0]  x_q, x_nxt;
        logic [10:0] x_w, y_sum, y_w;

        assign x_w   = {1'b0, x_q};
        assign y_sum = 11'(Y_BASE) + {2'b00, scroll_q};
        assign y_w   = (y_sum >= 11'd480) ? y_sum - 11'd480 : y_sum;

        if ((gi % 2) == 0) begin : g_right
            logic [10:0] sum;
            assign sum   = x_w + {8'b0, speed};
            assign x_nxt = (sum >= 11'd640) ? 10'(sum - 11'd640) : sum[9:0];
        end else begin : g_left
            assign x_nxt = (x_q < {7'b0, speed}) ? 10'(x_w + 11'd640 - {8'b0, speed})
                                                 : x_q - {7'b0, speed};
        end

        // Body ends at x+OB_W; hpos never exceeds 639 so the right edge clips naturally.
        assign obs_hit[gi] = (hpos11 >= x_w) && (hpos11 < x_w + 11'(OB_W)) &&
                             (vpos11 >= y_w) && (vpos11 < y_w + 11'(OB_H));

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n)       x_q <= 10'(X_RST);
            else if (lanes_rst) x_q <= 10'(X_RST);
            else if (lanes_adv) x_q <= x_nxt;
        end
    end

    always_comb begin
        state_d   = state_q;
        lives_d   = lives_q;
        cnt_d     = cnt_q;
        scroll_d  = scroll_q;
        score_d   = score_q;
        lanes_adv = 1'b0;
        lanes_rst = 1'b0;
        flag_clr  = i_frame_tick;
        case (state_q)
            ST_PLAY: begin
                if (move_pulse) begin
                    scroll_d = scroll_step(scroll_q);
                    score_d  = sat_inc(score_q);
                end
                if (i_frame_tick) begin
                    if (flag_q) begin
                        lives_d = lives_q - 3'd1;
                        if (lives_q == 3'd1) begin
                            state_d = ST_OVER;
                        end else begin
                            state_d = ST_HIT;
                            cnt_d   = CNT_W'(HIT_FRAMES - 1);
                        end
                    end else begin
                        lanes_adv = 1'b1;
                    end
                end
            end
            ST_HIT: begin
                if (i_frame_tick) begin
                    if (cnt_q == '0) begin
                        state_d  = ST_PLAY;
                        scroll_d = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            ST_OVER: begin
                if (move_pulse) begin
                    state_d   = ST_PLAY;
                    lives_d   = 3'(LIVES);
                    score_d   = '0;
                    scroll_d  = '0;
                    cnt_d     = '0;
                    lanes_rst = 1'b1;
                    flag_clr  = 1'b1;
                end
            end
            default: state_d = ST_PLAY;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_PLAY;
            lives_q  <= 3'(LIVES);
            cnt_q    <= '0;
            scroll_q <= '0;
            score_q  <= '0;
            btn_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            lives_q  <= lives_d;
            cnt_q    <= cnt_d;
            scroll_q <= scroll_d;
            score_q  <= score_d;
            btn_q    <= i_move_btn;
        end
    end

    // Clear has priority: the tick lands in blanking where no hit can be seen.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                                        flag_q <= 1'b0;
        else if (flag_clr)                                   flag_q <= 1'b0;
        else if (i_display_on && chick_hit && any_obs)       flag_q <= 1'b1;
    end

    always_comb begin
        rgb_d = 3'b000;
        if (!i_display_on)              rgb_d = 3'b000;
        else if (chick_hit && any_obs)  rgb_d = 3'b011;
        else if (any_obs)               rgb_d = 3'b100;
        else if (chick_hit)             rgb_d = (state_q == ST_HIT) ? 3'b111 : 3'b010;
        else                            rgb_d = (state_q == ST_OVER) ? 3'b101 : 3'b001;
    end

    // Pixel stage p1: colour registered one cycle behind hpos/vpos.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) rgb_p1 <= 3'b000;
        else          rgb_p1 <= rgb_d;
    end

    assign o_rgb   = rgb_p1;
    assign o_score = score_q;
    assign o_lives = lives_q;
    assign o_state = state_q;

endmodule

// File: tb/tb_crossy_lanes.sv
// Scoreboard bench for crossy_lanes: directed stimulus queues expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_crossy_lanes;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] hpos, vpos;
    logic       display_on, frame_tick, move_btn;
    logic [2:0] rgb;
    logic [7:0] score;
    logic [2:0] lives;
    logic [1:0] state;

    crossy_lanes dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_hpos      (hpos),
        .i_vpos      (vpos),
        .i_display_on(display_on),
        .i_frame_tick(frame_tick),
        .i_move_btn  (move_btn),
        .o_rgb       (rgb),
        .o_score     (score),
        .o_lives     (lives),
        .o_state     (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    sel;
        int    exp;
        int    due;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin : monitor
        exp_t e;
        int   act;
        forever begin
            @(negedge clk);
            while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
                e = sb_q.pop_front();
                case (e.sel)
                    0:       act = int'(rgb);
                    1:       act = int'(score);
                    2:       act = int'(lives);
                    default: act = int'(state);
                endcase
                n_checks++;
                if (act != e.exp) begin
                    n_fail++;
                    $display("FAIL %s: got %0d, expected %0d (cycle %0d)", e.name, act, e.exp, cyc);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string name, input int sel, input int exp, input int due);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = exp;
        e.due  = due;
        sb_q.push_back(e);
    endtask

    task automatic chk_px(input string name, input int x, input int y, input int exp);
        hpos       = 10'(x);
        vpos       = 10'(y);
        display_on = 1'b1;
        push(name, 0, exp, cyc + 1);
        step();
        display_on = 1'b0;
    endtask

    task automatic chk_reg(input string name, input int sel, input int exp);
        push(name, sel, exp, cyc);
    endtask

    task automatic ticks(input int n);
        frame_tick = 1'b1;
        repeat (n) step();
        frame_tick = 1'b0;
    endtask

    task automatic press(input int hold);
        move_btn = 1'b1;
        repeat (hold) step();
        move_btn = 1'b0;
        step();
    endtask

    initial begin
        rst_n      = 1'b0;
        hpos       = '0;
        vpos       = '0;
        display_on = 1'b0;
        frame_tick = 1'b0;
        move_btn   = 1'b0;
        step();
        step();
        n_checks++;
        if (rgb !== 3'b000) begin
            n_fail++;
            $display("FAIL direct_rst_rgb: got %0d, expected 0", rgb);
        end
        n_checks++;
        if (score !== 8'd0) begin
            n_fail++;
            $display("FAIL direct_rst_score: got %0d, expected 0", score);
        end
        n_checks++;
        if (lives !== 3'd3) begin
            n_fail++;
            $display("FAIL direct_rst_lives: got %0d, expected 3", lives);
        end
        n_checks++;
        if (state !== 2'b00) begin
            n_fail++;
            $display("FAIL direct_rst_state: got %0d, expected 0", state);
        end
        chk_reg("rst_rgb", 0, 0);
        chk_reg("rst_score", 1, 0);
        chk_reg("rst_lives", 2, 3);
        chk_reg("rst_state", 3, 0);
        step();
        rst_n = 1'b1;
        step();

        // Reset lane geometry: x = 0/250/500, y = 0/150/300.
        chk_px("rst_l0_left", 0, 0, 3'b100);
        chk_px("rst_l0_edge", 50, 0, 3'b001);
        chk_px("rst_l1_left", 250, 150, 3'b100);
        chk_px("rst_l1_pre", 249, 150, 3'b001);
        chk_px("rst_l2_corner", 549, 329, 3'b100);
        chk_px("rst_l2_below", 549, 330, 3'b001);
        chk_px("rst_chick", 310, 400, 3'b010);
        chk_px("rst_chick_right", 340, 400, 3'b001);

        // Lane motion at speed 1, including wrap in both directions.
        ticks(4);
        chk_px("t4_l0", 4, 0, 3'b100);
        chk_px("t4_l0_pre", 3, 0, 3'b001);
        chk_px("t4_l1", 246, 150, 3'b100);
        chk_px("t4_l1_end", 295, 150, 3'b100);
        chk_px("t4_l1_past", 296, 150, 3'b001);
        chk_px("t4_l2", 504, 300, 3'b100);
        ticks(246);
        chk_px("l1_at0", 0, 150, 3'b100);
        chk_px("l1_at0_edge", 50, 150, 3'b001);
        ticks(1);
        chk_px("l1_wrap639", 639, 150, 3'b100);
        chk_px("l1_wrap_0", 0, 150, 3'b001);
        ticks(387);
        chk_px("l0_638", 638, 0, 3'b100);
        chk_px("l0_638_pre", 637, 0, 3'b001);
        ticks(1);
        chk_px("l0_639", 639, 0, 3'b100);
        chk_px("l0_639_pre", 638, 0, 3'b001);
        ticks(1);
        chk_px("l0_wrap0", 0, 0, 3'b100);
        chk_px("l0_wrap_639", 639, 0, 3'b001);

        // Moves: three presses, then a long hold that counts once.
        repeat (3) press(5);
        chk_reg("score3", 1, 3);
        chk_px("scroll30_l0", 0, 30, 3'b100);
        chk_px("scroll30_l0_above", 0, 29, 3'b001);
        chk_px("scroll30_l1", 250, 180, 3'b100);
        chk_px("scroll30_l1_above", 250, 179, 3'b001);
        press(100);
        chk_reg("score_long_hold", 1, 4);
        chk_px("scroll40_l0", 0, 40, 3'b100);
        chk_px("scroll40_l0_above", 0, 39, 3'b001);

        // First collision: lane2 at x=300, y=390.
        repeat (5) press(5);
        ticks(440);
        chk_reg("score9", 1, 9);
        chk_px("obs_only", 305, 395, 3'b100);
        chk_px("chick_only", 320, 430, 3'b010);
        chk_px("overlap", 320, 410, 3'b011);
        ticks(1);
        chk_reg("hit_state", 3, 1);
        chk_reg("hit_lives", 2, 2);
        chk_px("hit_chick", 320, 430, 3'b111);
        chk_px("hit_bg", 600, 470, 3'b001);
        press(5);
        chk_reg("hit_press_ignored", 1, 9);
        ticks(59);
        chk_reg("hit_still", 3, 1);
        ticks(1);
        chk_reg("hit_done", 3, 0);
        chk_reg("hit_done_lives", 2, 2);
        chk_reg("hit_done_score", 1, 9);
        chk_px("scroll0_l2", 300, 300, 3'b100);
        chk_px("scroll0_l2_above", 300, 299, 3'b001);
        chk_px("frozen_l0", 440, 0, 3'b100);

        // Two more collisions run lives out.
        for (int k = 0; k < 2; k++) begin
            repeat (9) press(1);
            chk_reg("coll_score", 1, 18 + 9 * k);
            chk_px("coll_overlap", 320, 410, 3'b011);
            ticks(1);
            if (k == 0) begin
                chk_reg("coll2_state", 3, 1);
                chk_reg("coll2_lives", 2, 1);
                ticks(60);
                chk_reg("coll2_back", 3, 0);
            end else begin
                chk_reg("over_state", 3, 2);
                chk_reg("over_lives", 2, 0);
            end
        end
        chk_px("over_bg", 600, 470, 3'b101);
        ticks(3);
        chk_reg("over_hold_state", 3, 2);
        chk_reg("over_hold_lives", 2, 0);
        press(5);
        chk_reg("restart_state", 3, 0);
        chk_reg("restart_lives", 2, 3);
        chk_reg("restart_score", 1, 0);
        chk_px("restart_l0", 0, 0, 3'b100);
        chk_px("restart_l1", 250, 150, 3'b100);
        chk_px("restart_l2", 500, 300, 3'b100);
        chk_px("restart_l2_pre", 499, 300, 3'b001);
        chk_px("restart_bg", 600, 470, 3'b001);

        // Score saturation and top speed (4 pixels per frame).
        repeat (300) press(1);
        chk_reg("score_sat", 1, 255);
        ticks(1);
        chk_px("spd4_l0", 4, 120, 3'b100);
        chk_px("spd4_l0_pre", 3, 120, 3'b001);
        chk_px("spd4_l1", 246, 270, 3'b100);
        chk_px("spd4_l1_pre", 245, 270, 3'b001);
        chk_px("spd4_l2", 504, 420, 3'b100);
        chk_px("spd4_l2_pre", 503, 420, 3'b001);

        // Collide, then pull reset mid-freeze with 20 frames left.
        ticks(109);
        chk_px("fast_overlap", 320, 425, 3'b011);
        ticks(1);
        ticks(39);
        chk_reg("pre_rst_state", 3, 1);
        chk_reg("pre_rst_lives", 2, 2);
        hpos       = 10'd600;
        vpos       = 10'd470;
        display_on = 1'b1;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (rgb !== 3'b000) begin
            n_fail++;
            $display("FAIL direct_async_rgb: got %0d, expected 0", rgb);
        end
        n_checks++;
        if (state !== 2'b00) begin
            n_fail++;
            $display("FAIL direct_async_state: got %0d, expected 0", state);
        end
        n_checks++;
        if (lives !== 3'd3) begin
            n_fail++;
            $display("FAIL direct_async_lives: got %0d, expected 3", lives);
        end
        n_checks++;
        if (score !== 8'd0) begin
            n_fail++;
            $display("FAIL direct_async_score: got %0d, expected 0", score);
        end
        chk_reg("async_rst_rgb", 0, 0);
        chk_reg("async_rst_state", 3, 0);
        chk_reg("async_rst_lives", 2, 3);
        chk_reg("async_rst_score", 1, 0);
        step();
        display_on = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        chk_reg("post_rst_state", 3, 0);
        chk_px("post_rst_l0", 0, 0, 3'b100);
        chk_px("post_rst_l2", 500, 300, 3'b100);

        for (int i = 0; i < 20 && sb_q.size() > 0; i++) step();
        while (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL %s: never compared, expected %0d", e.name, e.exp);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
